rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer that sits directly downstream of the synchronized reset generator. It waits for the clock PLL to report lock, stretches the reset, then releases the core logic and the laser I/O logic in that order, a fixed gap apart, and finally asserts a ready flag. Losing lock re-enters the sequence. The top level drives `reset` from the inverted synchronized reset (`~sync_rst_n`).

## Interface
Parameters:
- `STRETCH_CYCLES`, 16: cycles reset is held after lock is seen; ≥1.
- `STAGE_GAP`, 4: cycles between successive releases; ≥1.
- `LOCK_TIMEOUT`, 1024: lock-wait watchdog limit, in cycles; ≥2.
- `CNT_W`, 16: counter width; must hold max(STRETCH_CYCLES, STAGE_GAP, LOCK_TIMEOUT).

Ports:
- `clk` input 1: single design clock.
- `reset` input 1: asynchronous, active-high reset.
- `pll_locked` input 1: asynchronous PLL lock indication; synchronized internally.
- `core_rst_n` output 1: core-logic reset, active-low.
- `io_rst_n` output 1: laser I/O reset, active-low.
- `seq_ready` output 1: sequence complete.
- `lock_timeout` output 1: sticky watchdog flag.
- `seq_state` output 3: current state, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lock_s`. Synchronizer flops reset to 0.
- States and encodings: WAIT_LOCK=0, STRETCH=1, CORE=2, IO=3, RUN=4. Encodings 5–7 are unreachable and go to WAIT_LOCK.
- One shared counter `cnt` of width CNT_W. It clears on every state change.
- WAIT_LOCK:
  - If `lock_s`=1, go to STRETCH.
  - Otherwise `cnt` increments and saturates at all-ones.
- STRETCH: when `cnt`==STRETCH_CYCLES-1, go to CORE. Otherwise increment `cnt`.
- CORE: when `cnt`==STAGE_GAP-1, go to IO. Otherwise increment `cnt`.
- IO: when `cnt`==STAGE_GAP-1, go to RUN. Otherwise increment `cnt`.
- RUN: remain in RUN.
- Lock loss: `lock_s`=0 in any state other than WAIT_LOCK forces WAIT_LOCK on the next edge. This takes priority over every other transition.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state:
  - `core_rst_n`=1 in CORE, IO and RUN.
  - `io_rst_n`=1 in IO and RUN.
  - `seq_ready`=1 in RUN only.
- Reset mid-operation: all state returns asynchronously to the reset values.
- Reset values: state=WAIT_LOCK, `cnt`=0, `core_rst_n`=0, `io_rst_n`=0, `seq_ready`=0, `lock_timeout`=0, `seq_state`=0.

## Timing
- Count edges from the first rising edge at which `pll_locked`=1 is sampled as edge 1. `pll_locked` must stay high throughout.
  - `lock_s` is 1 after edge 2.
  - STRETCH is entered at edge 3.
  - `core_rst_n` rises at edge 3+STRETCH_CYCLES (19 with defaults).
  - `io_rst_n` rises STAGE_GAP edges later (23).
  - `seq_ready` rises another STAGE_GAP edges later (27).
- Lock loss: all three outputs fall at edge 3 after `pll_locked` falls (2 synchronizer edges + 1 state edge).
- A lock glitch shorter than one cycle may be missed. Any glitch that is captured restarts the full sequence.
- While `reset`=1, outputs are held at their reset values regardless of `pll_locked`.

## Configuration
- Macro: `RST_SEQ_WDOG_EN`.
- Defined:
  - `lock_timeout` sets on the edge where `cnt` reaches LOCK_TIMEOUT-1 while in WAIT_LOCK with `lock_s`=0.
  - It stays set until `reset`. Acquiring lock afterwards does not clear it.
  - Sequencing is unaffected; the sequencer keeps waiting for lock.
- Undefined: `lock_timeout` is tied to 0 and the watchdog compare logic is omitted. State behaviour and `cnt` are identical.

## Test plan
- Reset and lock: assert `reset`, then release it, then raise `pll_locked` and hold it.
  - `core_rst_n`, `io_rst_n` and `seq_ready` stay 0 before lock.
  - They rise at edges 19, 23 and 27 (defaults).
  - `seq_state` steps 0→1→2→3→4.
- Lock loss in RUN: drop `pll_locked`.
  - All outputs are 0 at edge 3 and `seq_state`=0.
  - Re-raise lock: the full 19/23/27 sequence repeats.
- Lock loss during STRETCH, at edge 10: `core_rst_n` never rises; the sequence restarts from WAIT_LOCK.
- Reset mid-sequence: assert `reset` in IO state. All outputs go to 0 asynchronously, before the next clock edge.
- Watchdog (`RST_SEQ_WDOG_EN` defined, LOCK_TIMEOUT=8): hold `pll_locked`=0 after reset.
  - `lock_timeout`=1 after the 8th edge.
  - Raise lock: the sequence completes and `lock_timeout` stays 1.
  - Apply `reset`: `lock_timeout` clears.
- Watchdog compiled out: repeat the previous scenario. `lock_timeout` stays 0 throughout.

Source files
------------

// File: rtl/rst_seq.sv
`timescale 1ns/1ps
// rst_seq -- reset sequencer for the core and laser I/O reset domains.
//
// Waits for the PLL to report lock, holds reset for STRETCH_CYCLES, then
// releases the core logic, then the laser I/O logic STAGE_GAP cycles later,
// and after another STAGE_GAP cycles raises seq_ready. Losing lock at any
// point restarts the whole sequence from WAIT_LOCK.
//
// Optional feature macro: RST_SEQ_WDOG_EN
//   Defined   : lock_timeout is a sticky flag that sets when lock has not been
//               seen for LOCK_TIMEOUT cycles in WAIT_LOCK; cleared by reset.
//   Undefined : lock_timeout is tied to 0.
//
// Ports:
//   clk          in   design clock
//   reset        in   asynchronous active-high reset
//   pll_locked   in   asynchronous PLL lock, synchronized internally
//   core_rst_n   out  core-logic reset, active-low (registered)
//   io_rst_n     out  laser I/O reset, active-low (registered)
//   seq_ready    out  sequence complete (registered)
//   lock_timeout out  sticky lock-wait watchdog flag (registered)
//   seq_state    out  current state encoding, for debug
module rst_seq #(
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4,
  parameter int LOCK_TIMEOUT   = 1024,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       core_rst_n,
  output logic       io_rst_n,
  output logic       seq_ready,
  output logic       lock_timeout,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STRETCH   = 3'd1,
    CORE      = 3'd2,
    IO        = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  logic             lock_meta;
  logic             lock_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Two-flop synchronizer for the asynchronous lock indication.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the
  // synchronizer into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Next-state and shared counter logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      WAIT_LOCK: begin
        if (lock_s)              state_nxt = STRETCH;
        else if (cnt == CNT_MAX) cnt_nxt   = cnt;      // saturate
      end
      STRETCH: if (cnt == STRETCH_LAST) state_nxt = CORE;
      CORE:    if (cnt == GAP_LAST)     state_nxt = IO;
      IO:      if (cnt == GAP_LAST)     state_nxt = RUN;
      RUN:     cnt_nxt = cnt;                          // idle, nothing to time
      default: state_nxt = WAIT_LOCK;                  // unreachable encodings
    endcase
    // Lock loss outranks every other transition.
    if (state != WAIT_LOCK && !lock_s) state_nxt = WAIT_LOCK;
    if (state_nxt != state)            cnt_nxt   = '0;
  end

  // State, counter and outputs; outputs decode the next state so they move on
  // the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      core_rst_n <= 1'b0;
      io_rst_n   <= 1'b0;
      seq_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      core_rst_n <= (state_nxt == CORE) || (state_nxt == IO) || (state_nxt == RUN);
      io_rst_n   <= (state_nxt == IO) || (state_nxt == RUN);
      seq_ready  <= (state_nxt == RUN);
    end
  end

  assign seq_state = state;

`ifdef RST_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  logic wdog_hit;
  assign wdog_hit = (state == WAIT_LOCK) && !lock_s && (cnt == TIMEOUT_LAST);

  // Sticky: only reset clears it, acquiring lock later does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         lock_timeout <= 1'b0;
    else if (wdog_hit) lock_timeout <= 1'b1;
  end
`else
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
`timescale 1ns/1ps
// Testbench for rst_seq. Expected behaviour comes from an edge-counting model:
// the sequencer's position is a function of how many consecutive edges have
// sampled a synchronized lock of 1, and the watchdog of how many edges have
// been spent waiting with lock low.
module tb_rst_seq;

  localparam int STRETCH = 16;
  localparam int GAP     = 4;
  localparam int LT      = 8;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       core_rst_n;
  logic       io_rst_n;
  logic       seq_ready;
  logic       lock_timeout;
  logic [2:0] seq_state;
  logic [6:0] obs;

  rst_seq #(
    .STRETCH_CYCLES(STRETCH),
    .STAGE_GAP     (GAP),
    .LOCK_TIMEOUT  (LT),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .core_rst_n  (core_rst_n),
    .io_rst_n    (io_rst_n),
    .seq_ready   (seq_ready),
    .lock_timeout(lock_timeout),
    .seq_state   (seq_state)
  );

  always #5 clk = ~clk;

  assign obs = {seq_state, core_rst_n, io_rst_n, seq_ready, lock_timeout};

  int checks = 0;
  int passed = 0;

  // ---------------- reference model ----------------
  logic m_s1, m_s2;   // pll_locked as seen one and two edges ago
  int   m_n;          // consecutive edges with synchronized lock = 1
  int   m_wait;       // edges spent waiting for lock since entering WAIT
  bit   m_to;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_n = 0; m_wait = 0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic pll);
    logic ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll;
    if (ls) begin
      m_n++;
    end else if (m_n == 0) begin
      m_wait++;
      if (m_wait >= LT) m_to = 1'b1;
    end else begin
      m_n    = 0;
      m_wait = 0;
    end
  endtask

  function automatic int exp_state(input int n);
    if (n == 0)                          return 0;
    else if (n < 1 + STRETCH)            return 1;
    else if (n < 1 + STRETCH + GAP)      return 2;
    else if (n < 1 + STRETCH + 2 * GAP)  return 3;
    else                                 return 4;
  endfunction

  function automatic logic [6:0] exp_vec();
    int s;
    s = exp_state(m_n);
    return {s[2:0], (s >= 2) ? 1'b1 : 1'b0, (s >= 3) ? 1'b1 : 1'b0,
            (s == 4) ? 1'b1 : 1'b0, WDOG && m_to};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic pll);
    pll_locked = pll;
    @(posedge clk);
    model_edge(pll);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Holds lock high for 35 edges, comparing against the model every edge and
  // reporting the edge numbers at which each output first rose.
  task automatic run_sequence(input string name, output int ce, output int ie,
                              output int re, output bit steps_ok);
    logic [2:0] prev;
    int nsteps;
    bit bad;
    ce = -1; ie = -1; re = -1; nsteps = 0; bad = 1'b0;
    prev = seq_state;
    for (int e = 1; e <= 35; e++) begin
      tick(1'b1);
      checks++;
      if (obs !== exp_vec())
        $display("FAIL %s edge %0d: got %b want %b", name, e, obs, exp_vec());
      else
        passed++;
      if (core_rst_n === 1'b1 && ce < 0) ce = e;
      if (io_rst_n === 1'b1 && ie < 0)   ie = e;
      if (seq_ready === 1'b1 && re < 0)  re = e;
      if (seq_state !== prev) begin
        if (seq_state !== prev + 3'd1) bad = 1'b1;
        nsteps++;
        prev = seq_state;
      end
    end
    steps_ok = !bad && (nsteps == 4);
  endtask

  task automatic check_edges(input string name, input int ce, input int ie,
                             input int re, input bit steps_ok);
    checks++;
    if (ce !== 3 + STRETCH)
      $display("FAIL %s core_rst_n rise: got edge %0d want %0d", name, ce, 3 + STRETCH);
    else passed++;
    checks++;
    if (ie !== 3 + STRETCH + GAP)
      $display("FAIL %s io_rst_n rise: got edge %0d want %0d", name, ie, 3 + STRETCH + GAP);
    else passed++;
    checks++;
    if (re !== 3 + STRETCH + 2 * GAP)
      $display("FAIL %s seq_ready rise: got edge %0d want %0d", name, re, 3 + STRETCH + 2 * GAP);
    else passed++;
    checks++;
    if (!steps_ok)
      $display("FAIL %s seq_state steps: got irregular want 0-1-2-3-4", name);
    else passed++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) $display("FAIL reset_async: got %b want 0000000", obs);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      pll_locked = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 7'b0) $display("FAIL reset_hold %0d: got %b want 0000000", i, obs);
      else passed++;
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_lock_sequence();
    int ce, ie, re;
    bit ok;
    do_reset();
    run_sequence("lock_seq", ce, ie, re, ok);
    check_edges("lock_seq", ce, ie, re, ok);
  endtask

  task automatic test_lock_loss_run();
    int ce, ie, re;
    bit ok;
    // Entered in RUN from the previous test.
    for (int e = 1; e <= 3; e++) begin
      tick(1'b0);
      checks++;
      if (obs !== exp_vec())
        $display("FAIL loss_run edge %0d: got %b want %b", e, obs, exp_vec());
      else passed++;
    end
    checks++;
    if ({seq_state, core_rst_n, io_rst_n, seq_ready} !== 6'b0)
      $display("FAIL loss_run outputs at edge 3: got %b want 000000",
               {seq_state, core_rst_n, io_rst_n, seq_ready});
    else passed++;
    run_sequence("relock", ce, ie, re, ok);
    check_edges("relock", ce, ie, re, ok);
  endtask

  task automatic test_lock_loss_stretch();
    int ce, ie, re;
    bit ok;
    bit core_seen;
    do_reset();
    core_seen = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      tick((e < 10) ? 1'b1 : 1'b0);
      checks++;
      if (obs !== exp_vec())
        $display("FAIL loss_stretch edge %0d: got %b want %b", e, obs, exp_vec());
      else passed++;
      if (core_rst_n !== 1'b0) core_seen = 1'b1;
      if (e == 12) begin
        checks++;
        if (seq_state !== 3'd0) $display("FAIL loss_stretch state at edge 12: got %0d want 0", seq_state);
        else passed++;
      end
    end
    checks++;
    if (core_seen) $display("FAIL loss_stretch core_rst_n: got rise want none");
    else passed++;
    run_sequence("restart", ce, ie, re, ok);
    check_edges("restart", ce, ie, re, ok);
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    guard = 0;
    while (exp_state(m_n) != 3 && guard < 40) begin
      tick(1'b1);
      guard++;
    end
    checks++;
    if (seq_state !== 3'd3) $display("FAIL reset_mid reach IO: got %0d want 3", seq_state);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) $display("FAIL reset_mid async: got %b want 0000000", obs);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_watchdog();
    int ce, ie, re;
    bit ok;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0);
      checks++;
      if (obs !== exp_vec())
        $display("FAIL wdog edge %0d: got %b want %b", e, obs, exp_vec());
      else passed++;
      if (e == 7) begin
        checks++;
        if (lock_timeout !== 1'b0) $display("FAIL wdog early: got %b want 0", lock_timeout);
        else passed++;
      end
    end
    checks++;
    if (lock_timeout !== WDOG) $display("FAIL wdog at edge 8: got %b want %b", lock_timeout, WDOG);
    else passed++;
    run_sequence("wdog_lock", ce, ie, re, ok);
    check_edges("wdog_lock", ce, ie, re, ok);
    checks++;
    if ({seq_ready, lock_timeout} !== {1'b1, WDOG})
      $display("FAIL wdog sticky: got %b want %b", {seq_ready, lock_timeout}, {1'b1, WDOG});
    else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if (lock_timeout !== 1'b0) $display("FAIL wdog clear: got %b want 0", lock_timeout);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int cyc;
    logic lvl;
    int len;
    do_reset();
    cyc = 0;
    while (cyc < 3000) begin
      if ($urandom_range(0, 39) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b0) $display("FAIL random reset cycle %0d: got %b want 0000000", cyc, obs);
        else passed++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
      end
      lvl = 1'($urandom_range(0, 3) != 0);
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
      for (int i = 0; i < len; i++) begin
        tick(lvl);
        checks++;
        if (obs !== exp_vec())
          $display("FAIL random cycle %0d: got %b want %b", cyc, obs, exp_vec());
        else passed++;
        cyc++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    pll_locked = 1'b0;
    model_reset();
    test_reset();
    test_lock_sequence();
    test_lock_loss_run();
    test_lock_loss_stretch();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
